// File: rtl/fft_stage_ctrl_if.sv
// Handshake bundle between the stage scheduler / twiddle datapath and fft_stage_ctrl.
// master drives the start request and the multiplier's valid; slave is the controller.
interface fft_stage_ctrl_if #(
    parameter int LOG2N   = 4,
    parameter int STAGE_W = 2
);
    logic                 i_start;
    logic [STAGE_W-1:0]   i_stage;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    logic                 o_rd_en;
    logic [LOG2N-1:0]     o_addr_a;
    logic [LOG2N-1:0]     o_addr_b;
    logic [LOG2N-2:0]     o_tw_addr;
    logic                 o_mult_start;
    logic                 i_mult_valid;
    logic                 o_wr_en;

    modport master (
        output i_start, i_stage, i_mult_valid,
        input  o_busy, o_done, o_err, o_rd_en, o_addr_a, o_addr_b,
               o_tw_addr, o_mult_start, o_wr_en
    );

    modport slave (
        input  i_start, i_stage, i_mult_valid,
        output o_busy, o_done, o_err, o_rd_en, o_addr_a, o_addr_b,
               o_tw_addr, o_mult_start, o_wr_en
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Sequences the N/2 radix-2 DIT butterflies of one FFT stage over an in-place RAM.
// Latency: (N/2)*(4+M)+1 cycles from accepted start to o_done, M = multiplier wait cycles.
// Backpressure: stalls in WAIT until i_mult_valid; aborts with o_err after TIMEOUT cycles.
module fft_stage_ctrl #(
    parameter int LOG2N   = 4,
    parameter int STAGE_W = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    fft_stage_ctrl_if.slave bus
);
    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [KW-1:0] K_LAST   = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, READ, FETCH, MULT, WAIT, WRITE, DONE} state_t;

    state_t               state;
    logic [STAGE_W-1:0]   stage;
    logic [KW-1:0]        k;
    logic [CW-1:0]        wait_cnt;
    logic                 busy;
    logic                 rd_en;
    logic                 mult_start;
    logic                 wr_en;
    logic                 done;
    logic                 err;
    logic                 stage_ok;

    assign stage_ok = (32'(bus.i_stage) < 32'(LOG2N));

    // wait_cnt counts cycles since the mult_start pulse, so o_err lands TIMEOUT cycles after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            stage      <= '0;
            k          <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            mult_start <= 1'b0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_en      <= 1'b0;
            mult_start <= 1'b0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (stage_ok) begin
                            stage <= bus.i_stage;
                            k     <= '0;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                            state <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: state <= FETCH;
                FETCH: begin
                    mult_start <= 1'b1;
                    state      <= MULT;
                end
                MULT: begin
                    wait_cnt <= CW'(1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.i_mult_valid) begin
                        wr_en <= 1'b1;
                        state <= WRITE;
                    end else if (wait_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (k == K_LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        rd_en <= 1'b1;
                        state <= READ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [KW-1:0]    mask_k;
    logic [KW-1:0]    pos;
    logic [KW-1:0]    hi;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [KW-1:0]    tw;
    int               tw_sh;

    // Inserting a zero at bit position s of k yields the upper leg; the lower leg sits span above it.
    always_comb begin
        mask_k = ~({KW{1'b1}} << stage);
        pos    = k & mask_k;
        hi     = k & ~mask_k;
        span   = {{KW{1'b0}}, 1'b1} << stage;
        addr_a = {hi, 1'b0} | {1'b0, pos};
        addr_b = addr_a + span;
        tw_sh  = KW - int'(stage);
        tw     = pos << tw_sh;
    end

    assign bus.o_busy       = busy;
    assign bus.o_done       = done;
    assign bus.o_err        = err;
    assign bus.o_rd_en      = rd_en;
    assign bus.o_mult_start = mult_start;
    assign bus.o_wr_en      = wr_en;
    assign bus.o_addr_a     = busy ? addr_a : '0;
    assign bus.o_addr_b     = busy ? addr_b : '0;
    assign bus.o_tw_addr    = busy ? tw : '0;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: address sequences, latency, reset, timeout, illegal stage.
module tb_fft_stage_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.LOG2N(4), .STAGE_W(2)) bus ();
    fft_stage_ctrl_if #(.LOG2N(3), .STAGE_W(2)) bus3 ();

    fft_stage_ctrl #(.LOG2N(4), .STAGE_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    fft_stage_ctrl #(.LOG2N(3), .STAGE_W(2), .TIMEOUT(64)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int early_wr = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stage(input logic [1:0] st, output int t0);
        bus.i_stage = st;
        bus.i_start = 1'b1;
        t0 = cyc;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic run_bfly(input int m, input bit noise, input int ea, input int eb,
                            input int etw, input string tag);
        int n;
        n = 0;
        while (bus.o_rd_en !== 1'b1 && n < 12) begin tick(); n++; end
        chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 1);
        chk({tag, "_rd_a"}, 32'(bus.o_addr_a), ea);
        chk({tag, "_rd_b"}, 32'(bus.o_addr_b), eb);
        chk({tag, "_rd_tw"}, 32'(bus.o_tw_addr), etw);
        if (noise) begin
            bus.i_start = 1'b1;
            bus.i_stage = 2'd0;
        end
        tick();
        bus.i_start = 1'b0;
        n = 0;
        while (bus.o_mult_start !== 1'b1 && n < 12) begin tick(); n++; end
        chk({tag, "_mult_start"}, 32'(bus.o_mult_start), 1);
        if (noise) bus.i_mult_valid = 1'b1;
        repeat (m) begin
            tick();
            bus.i_mult_valid = 1'b0;
            if (bus.o_wr_en === 1'b1) early_wr++;
        end
        bus.i_mult_valid = 1'b1;
        tick();
        bus.i_mult_valid = 1'b0;
        chk({tag, "_wr_en"}, 32'(bus.o_wr_en), 1);
        chk({tag, "_wr_a"}, 32'(bus.o_addr_a), ea);
        chk({tag, "_wr_b"}, 32'(bus.o_addr_b), eb);
        chk({tag, "_wr_tw"}, 32'(bus.o_tw_addr), etw);
    endtask

    task automatic finish_stage(input int t0, input int lat, input string tag);
        tick();
        chk({tag, "_done"}, 32'(bus.o_done), 1);
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
        tick();
        chk({tag, "_busy_after"}, 32'(bus.o_busy), 0);
        chk({tag, "_done_after"}, 32'(bus.o_done), 0);
    endtask

    initial begin
        int t0;
        int tm;
        int n;
        int wr_seen;
        int done_seen;
        int s1a[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
        int s1tw[8] = '{0, 4, 0, 4, 0, 4, 0, 4};

        bus.i_start = 1'b0;
        bus.i_stage = '0;
        bus.i_mult_valid = 1'b0;
        bus3.i_start = 1'b0;
        bus3.i_stage = '0;
        bus3.i_mult_valid = 1'b0;

        #1;
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_rd_en", 32'(bus.o_rd_en), 0);
        chk("rst_addr_b", 32'(bus.o_addr_b), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a stage-2 WAIT
        start_stage(2'd2, t0);
        chk("s2_busy", 32'(bus.o_busy), 1);
        chk("s2_rd_b", 32'(bus.o_addr_b), 4);
        tick();
        tick();
        chk("s2_mult_start", 32'(bus.o_mult_start), 1);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.o_busy), 0);
        chk("midrst_addr_b", 32'(bus.o_addr_b), 0);
        chk("midrst_wr_en", 32'(bus.o_wr_en), 0);
        chk("midrst_mult_start", 32'(bus.o_mult_start), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("postrst_busy", 32'(bus.o_busy), 0);
        chk("postrst_rd_en", 32'(bus.o_rd_en), 0);

        // Stage 0, multiplier answers 17 cycles after each start
        start_stage(2'd0, t0);
        for (int k = 0; k < 8; k++)
            run_bfly(17, 1'b0, 2 * k, 2 * k + 1, 0, $sformatf("s0_k%0d", k));
        finish_stage(t0, 8 * (4 + 17) + 1, "s0");

        // Stage 3, legal for LOG2N=4
        start_stage(2'd3, t0);
        chk("s3_busy", 32'(bus.o_busy), 1);
        chk("s3_err", 32'(bus.o_err), 0);
        for (int k = 0; k < 8; k++)
            run_bfly(1, 1'b0, k, k + 8, k, $sformatf("s3_k%0d", k));
        finish_stage(t0, 8 * (4 + 1) + 1, "s3");

        // Stage 1, with a stray start and an early valid in the first butterfly
        early_wr = 0;
        start_stage(2'd1, t0);
        for (int k = 0; k < 8; k++)
            run_bfly(3, (k == 0), s1a[k], s1a[k] + 2, s1tw[k], $sformatf("s1_k%0d", k));
        chk("s1_early_wr", 32'(early_wr), 0);
        finish_stage(t0, 8 * (4 + 3) + 1, "s1");

        // Multiplier never answers
        start_stage(2'd2, t0);
        tick();
        tick();
        chk("to_mult_start", 32'(bus.o_mult_start), 1);
        tm = cyc;
        n = 0;
        wr_seen = 0;
        done_seen = 0;
        while (bus.o_err !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (bus.o_wr_en === 1'b1) wr_seen++;
            if (bus.o_done === 1'b1) done_seen++;
        end
        chk("to_err", 32'(bus.o_err), 1);
        chk("to_err_delay", 32'(cyc - tm), 64);
        chk("to_busy", 32'(bus.o_busy), 0);
        chk("to_wr_seen", 32'(wr_seen), 0);
        chk("to_done_seen", 32'(done_seen), 0);
        tick();
        chk("to_err_pulse", 32'(bus.o_err), 0);
        chk("to_idle_rd_en", 32'(bus.o_rd_en), 0);
        chk("to_idle_busy", 32'(bus.o_busy), 0);

        // Stage 3 is illegal when LOG2N=3
        bus3.i_stage = 2'd3;
        bus3.i_start = 1'b1;
        tick();
        bus3.i_start = 1'b0;
        chk("ill_err", 32'(bus3.o_err), 1);
        chk("ill_busy", 32'(bus3.o_busy), 0);
        chk("ill_rd_en", 32'(bus3.o_rd_en), 0);
        tick();
        chk("ill_err_pulse", 32'(bus3.o_err), 0);
        chk("ill_busy_later", 32'(bus3.o_busy), 0);
        chk("ill_rd_en_later", 32'(bus3.o_rd_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
